pr_hrav_dispatcher_nx: RTL and testbench



---
 rtl/pr_hrav_disp_pkg.sv | 27 ++
 rtl/pr_hrav_disp_skid.sv | 49 ++++
 rtl/pr_hrav_dispatcher_nx.sv | 217 +++++++++++++++++++++
 tb/tb_pr_hrav_dispatcher_nx.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pr_hrav_disp_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// pr_hrav_disp_pkg: header layout and FSM encodings for the dispatcher.
// Rev 1.0
// ------------------------------------------------------------------
package pr_hrav_disp_pkg;

  localparam int TYPE_LSB   = 24;
  localparam int CORE_LSB   = 26;
  localparam int PR_END_BIT = 28;

  localparam logic [1:0] HDR_ICAP = 2'b11;

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } disp_state_t;

  typedef enum logic [1:0] {
    PR_IDLE = 2'd0,
    PR_LOAD = 2'd1,
    PR_WAIT = 2'd2
  } pr_state_t;

endpackage
`default_nettype wire

// File: rtl/pr_hrav_disp_skid.sv
`default_nettype none
// ------------------------------------------------------------------
// pr_hrav_disp_skid: 2-entry registered valid/ready skid buffer.
// Rev 1.0
// ------------------------------------------------------------------
module pr_hrav_disp_skid #(
  parameter int WIDTH = 8
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             out_free;

  // Ready depends only on the skid register, never on the downstream ready.
  assign in_ready = ~skid_valid;
  assign out_free = out_ready | ~out_valid;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_free) begin
      out_valid  <= skid_valid | in_valid;
      skid_valid <= 1'b0;
    end else if (in_valid && !skid_valid) begin
      skid_valid <= 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (out_free) begin
      out_data <= skid_valid ? skid_data : in_data;
    end
    if (!out_free && !skid_valid) begin
      skid_data <= in_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pr_hrav_dispatcher_nx.sv
`default_nettype none
// ------------------------------------------------------------------
// pr_hrav_dispatcher_nx: routes whole AXIS packets to NUM_CORES scanners or ICAP.
// Optional packet counters: define PR_HRAV_DISP_STATS_EN.   Rev 1.0
// ------------------------------------------------------------------
module pr_hrav_dispatcher_nx
  import pr_hrav_disp_pkg::*;
#(
  parameter int DATA_W    = 256,
  parameter int USER_W    = 16,
  parameter int NUM_CORES = 4,
  parameter int SEL_W     = 2
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [NUM_CORES-1:0]            core_enb,
  input  logic                            dbg_force_en,
  input  logic [NUM_CORES:0]              dbg_force_dst,
  input  logic [DATA_W-1:0]               S_AXIS_TDATA,
  input  logic [DATA_W/8-1:0]             S_AXIS_TSTRB,
  input  logic [127:0]                    S_AXIS_TUSER,
  input  logic                            S_AXIS_TLAST,
  input  logic                            S_AXIS_TVALID,
  output logic                            S_AXIS_TREADY,
  output logic [NUM_CORES*DATA_W-1:0]     M_CORE_TDATA,
  output logic [NUM_CORES*DATA_W/8-1:0]   M_CORE_TSTRB,
  output logic [NUM_CORES*USER_W-1:0]     M_CORE_TUSER,
  output logic [NUM_CORES-1:0]            M_CORE_TLAST,
  output logic [NUM_CORES-1:0]            M_CORE_TVALID,
  input  logic [NUM_CORES-1:0]            M_CORE_TREADY,
  output logic [DATA_W-1:0]               M_ICAP_TDATA,
  output logic [DATA_W/8-1:0]             M_ICAP_TSTRB,
  output logic [USER_W-1:0]               M_ICAP_TUSER,
  output logic                            M_ICAP_TLAST,
  output logic                            M_ICAP_TVALID,
  input  logic                            M_ICAP_TREADY,
  output logic                            pr_busy,
  output logic [SEL_W-1:0]                pr_core,
`ifdef PR_HRAV_DISP_STATS_EN
  output logic [(NUM_CORES+2)*32-1:0]     stat_pkt_cnt,
`endif
  output logic                            drop_pulse
);

  localparam int ND = NUM_CORES + 1;
  localparam int PW = DATA_W + DATA_W/8 + USER_W + 1;

  logic [NUM_CORES-1:0] enb_meta, enb_sync, eligible;
  disp_state_t          state, state_nxt;
  pr_state_t            pr_state, pr_state_nxt;
  logic [ND-1:0]        lat_dst, sel_dst, cur_dst, hdr_dst, low_dst;
  logic [ND-1:0]        buf_in_ready, buf_in_valid;
  logic                 hdr_ok, hdr_icap, hdr_end, lat_icap_end;
  logic [SEL_W-1:0]     hdr_core;
  logic                 tready, accept, pkt_last, icap_hdr_acc, icap_end_now, core_done;
  logic [PW-1:0]        in_payload;
  logic                 unused_tuser;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      enb_meta <= '0;
      enb_sync <= '0;
    end else begin
      enb_meta <= core_enb;
      enb_sync <= enb_meta;
    end
  end

  // Header decode is gated by TVALID so idle-bus garbage never steers control.
  assign hdr_icap = S_AXIS_TVALID && (S_AXIS_TDATA[TYPE_LSB +: 2] == HDR_ICAP);
  assign hdr_end  = S_AXIS_TVALID && S_AXIS_TDATA[PR_END_BIT];
  assign hdr_core = S_AXIS_TVALID ? S_AXIS_TDATA[CORE_LSB +: SEL_W] : '0;

  assign pr_busy = (pr_state != PR_IDLE);

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_elig
    assign eligible[i] = enb_sync[i] & ~(pr_busy & (pr_core == SEL_W'(i)));
  end

  always_comb begin
    hdr_dst = '0;
    low_dst = '0;
    hdr_ok  = 1'b0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        low_dst    = '0;
        low_dst[i] = 1'b1;
      end
      if (eligible[i] && (hdr_core == SEL_W'(i))) begin
        hdr_ok     = 1'b1;
        hdr_dst[i] = 1'b1;
      end
    end
    sel_dst = '0;
    if (hdr_icap) begin
      sel_dst[NUM_CORES] = 1'b1;
    end else if (dbg_force_en) begin
      sel_dst = dbg_force_dst;
    end else if (hdr_ok) begin
      sel_dst = hdr_dst;
    end else begin
      sel_dst = low_dst;
    end
  end

  // An all-zero destination means drop: no buffer gates TREADY.
  assign cur_dst       = (state == HDR) ? sel_dst : lat_dst;
  assign tready        = ARESETN && (&(buf_in_ready | ~cur_dst));
  assign S_AXIS_TREADY = tready;
  assign accept        = S_AXIS_TVALID && tready;
  assign pkt_last      = accept && S_AXIS_TLAST;
  assign buf_in_valid  = {ND{accept}} & cur_dst;
  assign icap_hdr_acc  = accept && (state == HDR) && hdr_icap;
  assign icap_end_now  = pkt_last && ((state == HDR) ? (hdr_icap && hdr_end) : lat_icap_end);

  always_comb begin
    state_nxt = state;
    case (state)
      HDR:       if (accept && !S_AXIS_TLAST) state_nxt = (sel_dst == '0) ? DROP : FWD;
      FWD, DROP: if (pkt_last) state_nxt = HDR;
      default:   state_nxt = HDR;
    endcase
  end

  // A core id outside the populated range has nothing to wait for.
  always_comb begin
    core_done = 1'b1;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (pr_core == SEL_W'(i)) core_done = enb_sync[i];
    end
    pr_state_nxt = pr_state;
    case (pr_state)
      PR_IDLE: if (icap_hdr_acc) pr_state_nxt = icap_end_now ? PR_WAIT : PR_LOAD;
      PR_LOAD: if (icap_end_now) pr_state_nxt = PR_WAIT;
      PR_WAIT: if (core_done) pr_state_nxt = PR_IDLE;
      default: pr_state_nxt = PR_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state        <= HDR;
      pr_state     <= PR_IDLE;
      lat_dst      <= '0;
      lat_icap_end <= 1'b0;
      pr_core      <= '0;
      drop_pulse   <= 1'b0;
    end else begin
      state      <= state_nxt;
      pr_state   <= pr_state_nxt;
      drop_pulse <= accept && (state == HDR) && (sel_dst == '0);
      if (accept && (state == HDR)) begin
        lat_dst      <= sel_dst;
        lat_icap_end <= hdr_icap && hdr_end;
      end
      if (icap_hdr_acc && (pr_state == PR_IDLE)) begin
        pr_core <= hdr_core;
      end
    end
  end

  assign in_payload   = {S_AXIS_TLAST, S_AXIS_TUSER[USER_W-1:0], S_AXIS_TSTRB, S_AXIS_TDATA};
  assign unused_tuser = ^S_AXIS_TUSER[127:USER_W];

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    logic [PW-1:0] out_data;
    logic          rd_ready;

    // Absent or reconfiguring cores drain their buffer so nothing upstream stalls.
    assign rd_ready = M_CORE_TREADY[i] | ~enb_sync[i] | (pr_busy & (pr_core == SEL_W'(i)));

    pr_hrav_disp_skid #(.WIDTH(PW)) u_skid (
      .ACLK      (ACLK),
      .ARESETN   (ARESETN),
      .in_valid  (buf_in_valid[i]),
      .in_ready  (buf_in_ready[i]),
      .in_data   (in_payload),
      .out_valid (M_CORE_TVALID[i]),
      .out_ready (rd_ready),
      .out_data  (out_data)
    );

    assign {M_CORE_TLAST[i], M_CORE_TUSER[i*USER_W +: USER_W],
            M_CORE_TSTRB[i*(DATA_W/8) +: DATA_W/8], M_CORE_TDATA[i*DATA_W +: DATA_W]} = out_data;
  end

  pr_hrav_disp_skid #(.WIDTH(PW)) u_skid_icap (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .in_valid  (buf_in_valid[NUM_CORES]),
    .in_ready  (buf_in_ready[NUM_CORES]),
    .in_data   (in_payload),
    .out_valid (M_ICAP_TVALID),
    .out_ready (M_ICAP_TREADY),
    .out_data  ({M_ICAP_TLAST, M_ICAP_TUSER, M_ICAP_TSTRB, M_ICAP_TDATA})
  );

`ifdef PR_HRAV_DISP_STATS_EN
  // Slots 0..NUM_CORES-1 are cores, NUM_CORES is ICAP, NUM_CORES+1 is drop.
  logic [NUM_CORES+1:0][31:0] pkt_cnt;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      pkt_cnt <= '0;
    end else if (pkt_last) begin
      for (int i = 0; i < ND; i++) begin
        if (cur_dst[i] && (pkt_cnt[i] != 32'hFFFF_FFFF)) pkt_cnt[i] <= pkt_cnt[i] + 32'd1;
      end
      if ((cur_dst == '0) && (pkt_cnt[ND] != 32'hFFFF_FFFF)) pkt_cnt[ND] <= pkt_cnt[ND] + 32'd1;
    end
  end

  assign stat_pkt_cnt = pkt_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pr_hrav_dispatcher_nx.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_pr_hrav_dispatcher_nx: directed self-checking bench for the dispatcher.
// Rev 1.0
// ------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pr_hrav_dispatcher_nx;

  localparam int DATA_W = 256;
  localparam int USER_W = 16;
  localparam int NC     = 4;
  localparam int SEL_W  = 2;

  logic                   ACLK = 1'b0;
  logic                   ARESETN = 1'b0;
  logic [NC-1:0]          core_enb = '1;
  logic                   dbg_force_en = 1'b0;
  logic [NC:0]            dbg_force_dst = '0;
  logic [DATA_W-1:0]      s_tdata = '0;
  logic [DATA_W/8-1:0]    s_tstrb = '1;
  logic [127:0]           s_tuser = '0;
  logic                   s_tlast = 1'b0;
  logic                   s_tvalid = 1'b0;
  logic                   s_tready;
  logic [NC*DATA_W-1:0]   m_core_tdata;
  logic [NC*DATA_W/8-1:0] m_core_tstrb;
  logic [NC*USER_W-1:0]   m_core_tuser;
  logic [NC-1:0]          m_core_tlast, m_core_tvalid;
  logic [NC-1:0]          m_core_tready = '1;
  logic [DATA_W-1:0]      m_icap_tdata;
  logic [DATA_W/8-1:0]    m_icap_tstrb;
  logic [USER_W-1:0]      m_icap_tuser;
  logic                   m_icap_tlast, m_icap_tvalid;
  logic                   m_icap_tready = 1'b1;
  logic                   pr_busy;
  logic [SEL_W-1:0]       pr_core;
  logic                   drop_pulse;
`ifdef PR_HRAV_DISP_STATS_EN
  logic [(NC+2)*32-1:0]   stat_pkt_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int drop_cnt = 0;
  int valid_cnt = 0;

  typedef struct packed {
    logic [2:0]  port;
    logic        last;
    logic [31:0] data;
  } beat_t;
  beat_t cap[$];

  pr_hrav_dispatcher_nx #(.DATA_W(DATA_W), .USER_W(USER_W), .NUM_CORES(NC), .SEL_W(SEL_W)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .core_enb(core_enb),
    .dbg_force_en(dbg_force_en), .dbg_force_dst(dbg_force_dst),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TSTRB(s_tstrb), .S_AXIS_TUSER(s_tuser),
    .S_AXIS_TLAST(s_tlast), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready),
    .M_CORE_TDATA(m_core_tdata), .M_CORE_TSTRB(m_core_tstrb), .M_CORE_TUSER(m_core_tuser),
    .M_CORE_TLAST(m_core_tlast), .M_CORE_TVALID(m_core_tvalid), .M_CORE_TREADY(m_core_tready),
    .M_ICAP_TDATA(m_icap_tdata), .M_ICAP_TSTRB(m_icap_tstrb), .M_ICAP_TUSER(m_icap_tuser),
    .M_ICAP_TLAST(m_icap_tlast), .M_ICAP_TVALID(m_icap_tvalid), .M_ICAP_TREADY(m_icap_tready),
    .pr_busy(pr_busy), .pr_core(pr_core),
`ifdef PR_HRAV_DISP_STATS_EN
    .stat_pkt_cnt(stat_pkt_cnt),
`endif
    .drop_pulse(drop_pulse)
  );

  always #5 ACLK = ~ACLK;

  // Inputs change just after posedge; handshakes are observed at negedge.
  always @(negedge ACLK) begin
    for (int i = 0; i < NC; i++) begin
      if (m_core_tvalid[i] && m_core_tready[i])
        cap.push_back({3'(i), m_core_tlast[i], m_core_tdata[i*DATA_W +: 32]});
    end
    if (m_icap_tvalid && m_icap_tready) cap.push_back({3'd4, m_icap_tlast, m_icap_tdata[31:0]});
    if (drop_pulse) drop_cnt++;
    if ((|m_core_tvalid) || m_icap_tvalid) valid_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last, output int stalls);
    stalls   = 0;
    s_tdata  = '0;
    s_tdata[31:0] = d;
    s_tuser  = {112'h0, d[15:0]};
    s_tlast  = last;
    s_tvalid = 1'b1;
    @(negedge ACLK);
    while (!s_tready && stalls < 200) begin
      @(negedge ACLK);
      stalls++;
    end
    if (stalls >= 200) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: beat %08h not accepted within 200 cycles", d);
    end
    @(posedge ACLK);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic test_reset;
    ARESETN = 1'b0;
    idle(3);
    n_cmp++; if (m_core_tvalid !== 4'b0 || m_icap_tvalid !== 1'b0) begin n_err++;
      $display("FAIL rst_valid: core=%b icap=%b want 0", m_core_tvalid, m_icap_tvalid); end
    n_cmp++; if (s_tready !== 1'b0) begin n_err++; $display("FAIL rst_tready: got %b want 0", s_tready); end
    n_cmp++; if (pr_busy !== 1'b0 || pr_core !== 2'd0 || drop_pulse !== 1'b0) begin n_err++;
      $display("FAIL rst_pr: busy=%b core=%0d drop=%b want 0/0/0", pr_busy, pr_core, drop_pulse); end
    ARESETN = 1'b1;
    idle(3);
  endtask

  task automatic test_route;
    int st;
    logic [31:0] exp_d[4] = '{32'h0800_0001, 32'h0000_0102, 32'h0000_0103, 32'h0000_0104};
    cap.delete();
    send_beat(exp_d[0], 1'b0, st);
    n_cmp++; if (m_core_tvalid !== 4'b0100 || m_icap_tvalid !== 1'b0) begin n_err++;
      $display("FAIL route_latency: core valid=%b icap=%b want 0100/0", m_core_tvalid, m_icap_tvalid); end
    for (int k = 1; k < 4; k++) send_beat(exp_d[k], k == 3, st);
    idle(4);
    n_cmp++; if (cap.size() !== 4) begin n_err++; $display("FAIL route_count: got %0d want 4", cap.size()); end
    for (int k = 0; k < 4 && k < cap.size(); k++) begin
      n_cmp++; if (cap[k] !== {3'd2, k == 3, exp_d[k]}) begin n_err++;
        $display("FAIL route_beat%0d: got %h want %h", k, cap[k], {3'd2, k == 3, exp_d[k]}); end
    end
  endtask

  task automatic test_redirect;
    int st;
    beat_t exp_b[5];
    cap.delete();
    core_enb = 4'b1011;
    idle(3);
    send_beat(32'h0800_0010, 1'b0, st); send_beat(32'h0000_0011, 1'b1, st);
    send_beat(32'h0C00_0020, 1'b0, st); send_beat(32'h0000_0021, 1'b1, st);
    dbg_force_en = 1'b1; dbg_force_dst = 5'b10000;
    send_beat(32'h0000_0030, 1'b1, st);
    dbg_force_en = 1'b0; dbg_force_dst = '0;
    idle(4);
    exp_b = '{{3'd0, 1'b0, 32'h0800_0010}, {3'd0, 1'b1, 32'h0000_0011},
              {3'd3, 1'b0, 32'h0C00_0020}, {3'd3, 1'b1, 32'h0000_0021},
              {3'd4, 1'b1, 32'h0000_0030}};
    n_cmp++; if (cap.size() !== 5) begin n_err++; $display("FAIL redir_count: got %0d want 5", cap.size()); end
    for (int k = 0; k < 5 && k < cap.size(); k++) begin
      n_cmp++; if (cap[k] !== exp_b[k]) begin n_err++;
        $display("FAIL redir_beat%0d: got %h want %h", k, cap[k], exp_b[k]); end
    end
  endtask

  task automatic test_drop;
    int st, tot;
    cap.delete();
    core_enb = 4'b0000;
    idle(3);
    drop_cnt = 0; valid_cnt = 0; tot = 0;
    send_beat(32'h0400_0040, 1'b0, st); tot += st;
    send_beat(32'h0000_0041, 1'b0, st); tot += st;
    send_beat(32'h0000_0042, 1'b1, st); tot += st;
    idle(3);
    n_cmp++; if (tot !== 0) begin n_err++; $display("FAIL drop_tready: stalled %0d cycles want 0", tot); end
    n_cmp++; if (drop_cnt !== 1) begin n_err++; $display("FAIL drop_pulse: got %0d pulses want 1", drop_cnt); end
    n_cmp++; if (valid_cnt !== 0 || cap.size() !== 0) begin n_err++;
      $display("FAIL drop_out: valid cycles %0d beats %0d want 0/0", valid_cnt, cap.size()); end
  endtask

  task automatic test_pr;
    int st;
    beat_t exp_b[6];
    cap.delete();
    core_enb = 4'b1111;
    idle(3);
    send_beat(32'h0700_0010, 1'b0, st);
    n_cmp++; if (pr_busy !== 1'b1 || pr_core !== 2'd1) begin n_err++;
      $display("FAIL pr_start: busy=%b core=%0d want 1/1", pr_busy, pr_core); end
    send_beat(32'h0000_0011, 1'b1, st);
    send_beat(32'h0400_0020, 1'b0, st); send_beat(32'h0000_0021, 1'b1, st);
    core_enb = 4'b1101;
    idle(4);
    send_beat(32'h1F00_0030, 1'b0, st); send_beat(32'h0000_0031, 1'b1, st);
    idle(3);
    n_cmp++; if (pr_busy !== 1'b1 || pr_core !== 2'd1) begin n_err++;
      $display("FAIL pr_wait: busy=%b core=%0d want 1/1", pr_busy, pr_core); end
    core_enb = 4'b1111;
    idle(1);
    n_cmp++; if (pr_busy !== 1'b1) begin n_err++; $display("FAIL pr_clr_early1: busy=%b want 1", pr_busy); end
    idle(1);
    n_cmp++; if (pr_busy !== 1'b1) begin n_err++; $display("FAIL pr_clr_early2: busy=%b want 1", pr_busy); end
    idle(1);
    n_cmp++; if (pr_busy !== 1'b0) begin n_err++; $display("FAIL pr_clr: busy=%b want 0", pr_busy); end
    idle(2);
    exp_b = '{{3'd4, 1'b0, 32'h0700_0010}, {3'd4, 1'b1, 32'h0000_0011},
              {3'd0, 1'b0, 32'h0400_0020}, {3'd0, 1'b1, 32'h0000_0021},
              {3'd4, 1'b0, 32'h1F00_0030}, {3'd4, 1'b1, 32'h0000_0031}};
    n_cmp++; if (cap.size() !== 6) begin n_err++; $display("FAIL pr_count: got %0d want 6", cap.size()); end
    for (int k = 0; k < 6 && k < cap.size(); k++) begin
      n_cmp++; if (cap[k] !== exp_b[k]) begin n_err++;
        $display("FAIL pr_beat%0d: got %h want %h", k, cap[k], exp_b[k]); end
    end
  endtask

  task automatic test_back_to_back;
    int st, viol, bad;
    logic done, prev_stall, pl;
    logic [31:0] pd;
    cap.delete();
    done = 1'b0; viol = 0; bad = 0; prev_stall = 1'b0; pl = 1'b0; pd = '0;
    fork
      begin
        send_beat(32'h0000_0500, 1'b0, st);
        for (int k = 1; k < 100; k++) send_beat(32'h0000_0500 + 32'(k), k == 99, st);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge ACLK); #1;
          m_core_tready[0] = 1'($urandom_range(0, 1));
        end
      end
      begin
        while (!done) begin
          @(negedge ACLK);
          if (prev_stall && (!m_core_tvalid[0] || m_core_tdata[31:0] !== pd || m_core_tlast[0] !== pl)) viol++;
          prev_stall = m_core_tvalid[0] && !m_core_tready[0];
          pd = m_core_tdata[31:0];
          pl = m_core_tlast[0];
        end
      end
    join
    m_core_tready[0] = 1'b1;
    idle(5);
    n_cmp++; if (viol !== 0) begin n_err++; $display("FAIL b2b_hold: %0d unstable stalled cycles want 0", viol); end
    n_cmp++; if (cap.size() !== 100) begin n_err++; $display("FAIL b2b_count: got %0d want 100", cap.size()); end
    for (int k = 0; k < 100 && k < cap.size(); k++) begin
      if (cap[k] !== {3'd0, k == 99, 32'h0000_0500 + 32'(k)}) begin
        if (bad == 0) $display("FAIL b2b_beat%0d: got %h want %h", k, cap[k], {3'd0, k == 99, 32'h0000_0500 + 32'(k)});
        bad++;
      end
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL b2b_data: %0d wrong beats want 0", bad); end
  endtask

  task automatic test_reset_mid;
    int st;
    cap.delete();
    m_core_tready[2] = 1'b0;
    send_beat(32'h0800_0060, 1'b0, st);
    send_beat(32'h0000_0061, 1'b0, st);
    n_cmp++; if (m_core_tvalid[2] !== 1'b1) begin n_err++; $display("FAIL mid_pre: core2 valid=%b want 1", m_core_tvalid[2]); end
    s_tdata = '0; s_tdata[31:0] = 32'h0000_0062; s_tvalid = 1'b1;
    ARESETN = 1'b0;
    @(negedge ACLK);
    n_cmp++; if (s_tready !== 1'b0) begin n_err++; $display("FAIL mid_tready: got %b want 0", s_tready); end
    @(posedge ACLK); #1;
    n_cmp++; if (m_core_tvalid !== 4'b0 || m_icap_tvalid !== 1'b0 || pr_busy !== 1'b0 || drop_pulse !== 1'b0) begin n_err++;
      $display("FAIL mid_flush: core=%b icap=%b busy=%b drop=%b want 0", m_core_tvalid, m_icap_tvalid, pr_busy, drop_pulse); end
    s_tvalid = 1'b0;
    ARESETN = 1'b1;
    m_core_tready[2] = 1'b1;
    idle(3);
    send_beat(32'h0C00_0070, 1'b1, st);
    idle(3);
    n_cmp++; if (cap.size() !== 1) begin n_err++; $display("FAIL mid_count: got %0d want 1", cap.size()); end
    n_cmp++; if (cap.size() > 0 && cap[0] !== {3'd3, 1'b1, 32'h0C00_0070}) begin n_err++;
      $display("FAIL mid_hdr: got %h want %h", cap[0], {3'd3, 1'b1, 32'h0C00_0070}); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_route();
    test_redirect();
    test_drop();
    test_pr();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
